// File: rtl/cnn_pll_reset_sequencer.sv
// cnn_pll_reset_sequencer: sequences the 150 MHz CNN PLL from the 50 MHz ref.
// Resets the PLL, qualifies lock, releases the CNN reset, retries on timeout.
//
// Ports:
//   clk        50 MHz reference clock (also the PLL refclk)
//   rst_n      asynchronous active-low reset
//   restart    single-cycle soft restart request
//   pll_locked PLL lock output, asynchronous to clk
//   pll_rst    active-high PLL reset
//   cnn_rst_n  active-low CNN-domain reset request (re-synchronized by consumer)
//   ready      PLL running and qualified
//   fail       retries exhausted
//   lol_sticky loss of lock seen in RUN, cleared by restart
//   retry_cnt  attempts used in current sequence, saturating
//   state_o    state encoding for debug
//   lol_count  lock-loss event count
//
// Optional: define CNN_PLL_LOL_COUNT_EN to build the lol_count counter;
// otherwise lol_count is tied to zero.

module cnn_pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        cnn_rst_n,
    output logic        ready,
    output logic        fail,
    output logic        lol_sticky,
    output logic [1:0]  retry_cnt,
    output logic [2:0]  state_o,
    output logic [15:0] lol_count
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LD = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             sync1_q;
    logic             lk_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             sticky_q, sticky_d;
    logic             pll_rst_q;
    logic             cnn_rst_n_q;
    logic             ready_q;
    logic             fail_q;

    // Two-flop synchronizer for the asynchronous lock; only lk_q is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        sticky_d = sticky_q;
        if (restart) begin
            state_d  = S_RESET;
            cnt_d    = HOLD_LD;
            retry_d  = 2'd0;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (cnt_q == '0) begin
                        state_d = S_WAIT;
                        cnt_d   = TO_LD;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_WAIT: begin
                    // Lock wins over a coincident timeout.
                    if (lk_q) begin
                        state_d = S_STABLE;
                        cnt_d   = STAB_LD;
                    end else if (cnt_q == '0) begin
                        if (32'(retry_q) < MAX_RETRY) begin
                            if (retry_q != 2'd3) begin
                                retry_d = retry_q + 2'd1;
                            end
                            state_d = S_RESET;
                            cnt_d   = HOLD_LD;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_STABLE: begin
                    // A lock glitch restarts the wait but is not a retry.
                    if (!lk_q) begin
                        state_d = S_WAIT;
                        cnt_d   = TO_LD;
                    end else if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_RUN: begin
                    if (!lk_q) begin
                        state_d  = S_RESET;
                        cnt_d    = HOLD_LD;
                        retry_d  = 2'd0;
                        sticky_d = 1'b1;
                    end
                end
                S_FAIL: begin
                end
                default: begin
                    state_d = S_RESET;
                    cnt_d   = HOLD_LD;
                end
            endcase
        end
    end

    // Outputs are registered from state_d so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            cnt_q       <= HOLD_LD;
            retry_q     <= 2'd0;
            sticky_q    <= 1'b0;
            pll_rst_q   <= 1'b1;
            cnn_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sticky_q    <= sticky_d;
            pll_rst_q   <= (state_d == S_RESET) || (state_d == S_FAIL);
            cnn_rst_n_q <= (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

`ifdef CNN_PLL_LOL_COUNT_EN
    logic        lol_evt;
    logic [15:0] lol_cnt_q;

    assign lol_evt = !restart && (state_q == S_RUN) && !lk_q;

    // Cleared only by rst_n so it survives soft restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lol_cnt_q <= 16'h0000;
        end else if (lol_evt && (lol_cnt_q != 16'hFFFF)) begin
            lol_cnt_q <= lol_cnt_q + 16'd1;
        end
    end

    assign lol_count = lol_cnt_q;
`else
    assign lol_count = 16'h0000;
`endif

    assign pll_rst    = pll_rst_q;
    assign cnn_rst_n  = cnn_rst_n_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign lol_sticky = sticky_q;
    assign retry_cnt  = retry_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_cnn_pll_reset_sequencer.sv
// tb_cnn_pll_reset_sequencer: scoreboard bench for the PLL reset sequencer.
// Each output-vector change is checked for value and cycle spacing.

module tb_cnn_pll_reset_sequencer;

    localparam logic [2:0] RST = 3'd0;
    localparam logic [2:0] WT  = 3'd1;
    localparam logic [2:0] STB = 3'd2;
    localparam logic [2:0] RUN = 3'd3;
    localparam logic [2:0] FL  = 3'd4;

`ifdef CNN_PLL_LOL_COUNT_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        pll_locked = 1'b0;
    logic        pll_rst;
    logic        cnn_rst_n;
    logic        ready;
    logic        fail;
    logic        lol_sticky;
    logic [1:0]  retry_cnt;
    logic [2:0]  state_o;
    logic [15:0] lol_count;

    cnn_pll_reset_sequencer #(
        .RST_HOLD_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE(8),
        .MAX_RETRY(2),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .restart(restart),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .cnn_rst_n(cnn_rst_n),
        .ready(ready),
        .fail(fail),
        .lol_sticky(lol_sticky),
        .retry_cnt(retry_cnt),
        .state_o(state_o),
        .lol_count(lol_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [25:0] v;
        int          d;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    wire [25:0] obs = {state_o, pll_rst, cnn_rst_n, ready,
                       fail, lol_sticky, retry_cnt, lol_count};

    function automatic logic [25:0] mk(input logic [2:0] s,
                                       input logic [1:0] r,
                                       input logic f,
                                       input logic sk,
                                       input int lol);
        logic [15:0] l;
        l = LC ? 16'(lol) : 16'h0000;
        return {s, (s == RST) || (s == FL), s == RUN, s == RUN,
                f, sk, r, l};
    endfunction

    task automatic ex(input logic [2:0] s, input logic [1:0] r,
                      input logic f, input logic sk,
                      input int lol, input int d);
        exp_t e;
        e.v = mk(s, r, f, sk, lol);
        e.d = d;
        q.push_back(e);
    endtask

    // Advance to 2 time units after posedge number k.
    task automatic at(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: every change of the output vector pops one expectation.
    initial begin : mon
        logic [25:0] last;
        int          lc;
        int          n;
        bit          first;
        exp_t        e;
        first = 1'b1;
        n     = 0;
        lc    = 0;
        last  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (first || (obs !== last)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_event cyc=%0d got=%h", cyc, obs);
                end else begin
                    e = q.pop_front();
                    if (obs !== e.v) begin
                        errors++;
                        $display("FAIL ev%0d_value cyc=%0d got=%h exp=%h",
                                 n, cyc, obs, e.v);
                    end
                    if (e.d >= 0) begin
                        checks++;
                        if ((cyc - lc) != e.d) begin
                            errors++;
                            $display("FAIL ev%0d_delay got=%0d exp=%0d",
                                     n, cyc - lc, e.d);
                        end
                    end
                end
                last  = obs;
                lc    = cyc;
                first = 1'b0;
                n++;
            end
        end
    end

    initial begin
        // Power-up, first lock, release.
        ex(RST, 2'd0, 1'b0, 1'b0, 0, -1);
        ex(WT,  2'd0, 1'b0, 1'b0, 0, 6);
        ex(STB, 2'd0, 1'b0, 1'b0, 0, 13);
        ex(RUN, 2'd0, 1'b0, 1'b0, 0, 8);
        at(3);   rst_n = 1'b1;
        at(17);  pll_locked = 1'b1;

        // Loss of lock in RUN, then relock.
        ex(RST, 2'd0, 1'b0, 1'b1, 1, 7);
        ex(WT,  2'd0, 1'b0, 1'b1, 1, 4);
        ex(STB, 2'd0, 1'b0, 1'b1, 1, 2);
        ex(RUN, 2'd0, 1'b0, 1'b1, 1, 8);
        at(32);  pll_locked = 1'b0;
        at(38);  pll_locked = 1'b1;

        // Restart, then a one-cycle glitch during STABLE.
        ex(RST, 2'd0, 1'b0, 1'b0, 1, 4);
        ex(WT,  2'd0, 1'b0, 1'b0, 1, 4);
        ex(STB, 2'd0, 1'b0, 1'b0, 1, 1);
        ex(WT,  2'd0, 1'b0, 1'b0, 1, 4);
        ex(STB, 2'd0, 1'b0, 1'b0, 1, 1);
        ex(RUN, 2'd0, 1'b0, 1'b0, 1, 8);
        at(52);  restart = 1'b1;
        at(53);  restart = 1'b0;
        at(59);  pll_locked = 1'b0;
        at(60);  pll_locked = 1'b1;

        // Restart coinciding with timeout, then with a lock rise.
        ex(RST, 2'd0, 1'b0, 1'b1, 2, 6);
        ex(WT,  2'd0, 1'b0, 1'b1, 2, 4);
        ex(RST, 2'd0, 1'b0, 1'b0, 2, 20);
        ex(WT,  2'd0, 1'b0, 1'b0, 2, 4);
        ex(RST, 2'd0, 1'b0, 1'b0, 2, 4);
        ex(WT,  2'd0, 1'b0, 1'b0, 2, 4);
        ex(STB, 2'd0, 1'b0, 1'b0, 2, 1);
        ex(RUN, 2'd0, 1'b0, 1'b0, 2, 8);
        at(74);  pll_locked = 1'b0;
        at(100); restart = 1'b1;
        at(101); restart = 1'b0;
        at(106); pll_locked = 1'b1;
        at(108); restart = 1'b1;
        at(109); restart = 1'b0;

        // No lock: retries exhausted, FAIL, then restart.
        ex(RST, 2'd0, 1'b0, 1'b0, 2, 3);
        ex(WT,  2'd0, 1'b0, 1'b0, 2, 4);
        ex(RST, 2'd1, 1'b0, 1'b0, 2, 20);
        ex(WT,  2'd1, 1'b0, 1'b0, 2, 4);
        ex(RST, 2'd2, 1'b0, 1'b0, 2, 20);
        ex(WT,  2'd2, 1'b0, 1'b0, 2, 4);
        ex(FL,  2'd2, 1'b1, 1'b0, 2, 20);
        ex(RST, 2'd0, 1'b0, 1'b0, 2, 9);
        ex(WT,  2'd0, 1'b0, 1'b0, 2, 4);
        ex(STB, 2'd0, 1'b0, 1'b0, 2, 3);
        at(124); pll_locked = 1'b0; restart = 1'b1;
        at(125); restart = 1'b0;
        at(205); restart = 1'b1;
        at(206); restart = 1'b0;
        at(210); pll_locked = 1'b1;

        // Async reset mid-STABLE, seen before the next clock edge.
        ex(RST, 2'd0, 1'b0, 1'b0, 0, 3);
        ex(WT,  2'd0, 1'b0, 1'b0, 0, 7);
        ex(STB, 2'd0, 1'b0, 1'b0, 0, 1);
        ex(RUN, 2'd0, 1'b0, 1'b0, 0, 8);
        at(216); rst_n = 1'b0;
        at(219); rst_n = 1'b1;

        at(240);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d left exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_pll_reset_sequencer.md
Name: cnn_pll_reset_sequencer

Overview:
- Sequences the 150 MHz CNN-domain PLL from the 50 MHz free-running reference domain.
- Drives the PLL's active-high reset and qualifies its asynchronous lock output.
- Releases the CNN-domain reset only after lock has been stable for a set time.
- Retries on lock timeout, re-sequences on loss of lock, and reports status to the HPS-visible control/status logic.

Parameters:
- RST_HOLD_CYCLES, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive synchronized-locked cycles required before release.
- MAX_RETRY, 3: attempts after the first before declaring failure.
- CNT_W, 16: width of the shared down-counter; must cover the largest cycle parameter.

Ports:
- clk, input, 1: 50 MHz reference clock, same net as the PLL refclk.
- rst_n, input, 1: asynchronous active-low reset.
- restart, input, 1: single-cycle soft restart request.
- pll_locked, input, 1: PLL locked output, asynchronous to clk.
- pll_rst, output, 1: active-high reset to the PLL.
- cnn_rst_n, output, 1: active-low reset request for the CNN domain; the consumer re-synchronizes it.
- ready, output, 1: PLL running and qualified.
- fail, output, 1: retries exhausted.
- lol_sticky, output, 1: a loss of lock occurred in RUN; cleared by restart.
- retry_cnt, output, 2: attempts used in the current sequence, saturating.
- state_o, output, 3: current state encoding, for debug.
- lol_count, output, 16: lock-loss event count (see Optional Feature).

Behaviour:
- Reset values: pll_rst=1, cnn_rst_n=0, ready=0, fail=0, lol_sticky=0, retry_cnt=0, state=RESET, counter loaded with RST_HOLD_CYCLES-1, lol_count=0.
- pll_locked passes through a 2-flop synchronizer; lk denotes the second flop. All decisions use lk only, so there is 2 cycles of input latency.
- All outputs are registered, decoded from the state register.
- State encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET:
  - pll_rst=1, cnn_rst_n=0.
  - Counter decrements each cycle; at 0, go to WAIT_LOCK and load LOCK_TIMEOUT-1.
  - pll_rst is therefore high for exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - lk=1: go to STABLE and load LOCK_STABLE-1.
  - Counter reaches 0 with lk=0:
    - If retry_cnt<MAX_RETRY: increment retry_cnt, go to RESET, load RST_HOLD_CYCLES-1.
    - Otherwise go to FAIL.
  - If lk=1 and the counter is 0 in the same cycle, lock wins.
- STABLE:
  - lk=0 at any point: return to WAIT_LOCK with a fresh LOCK_TIMEOUT. Glitches do not count as retries.
  - Counter reaches 0 with lk=1: go to RUN.
- RUN:
  - cnn_rst_n=1 and ready=1, both registered from the first RUN cycle.
  - lk=0:
    - Next cycle: cnn_rst_n=0, ready=0, lol_sticky=1.
    - retry_cnt cleared; go to RESET with a fresh RST_HOLD_CYCLES.
- FAIL:
  - pll_rst=1 and cnn_rst_n=0, held indefinitely; fail=1.
  - Left only via restart or rst_n.
- restart=1 in any state:
  - Next state is RESET; counter loaded; retry_cnt=0; fail=0; lol_sticky=0.
  - restart has priority over every other transition in the same cycle.
  - restart held high keeps the block in RESET, and the counter restarts each cycle.
- rst_n asserted mid-operation: all registers, including the synchronizer, return to reset values immediately (asynchronous). The release path is the normal sequence.
- retry_cnt saturates at 3.
- MAX_RETRY=0 means a single attempt: the first timeout goes straight to FAIL.

Optional Feature:
- Macro: CNN_PLL_LOL_COUNT_EN.
- Defined:
  - lol_count increments by 1 on each RUN→RESET transition caused by loss of lock.
  - It saturates at 16'hFFFF.
  - It is cleared by rst_n only, not by restart.
- Undefined: lol_count is tied to 16'h0000 and no counter register is synthesized.

Test Plan:
(Params for the bench: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.)
1. Release rst_n; raise pll_locked 10 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; ready=1 and cnn_rst_n=1 exactly 2+8 cycles after lk-rise sampling; retry_cnt=0.
2. Keep pll_locked=0 -> three RESET(4)/WAIT_LOCK(20) cycles; retry_cnt goes 1 then 2; fail=1 after the third timeout; pll_rst stays 1. Then pulse restart -> fail=0, retry_cnt=0, new sequence starts.
3. In STABLE, drop pll_locked for 1 cycle at stable count 5 -> back to WAIT_LOCK, no retry increment; ready asserts 8 full cycles after lock returns.
4. In RUN, drop pll_locked -> ready=0 and cnn_rst_n=0 within 3 cycles; lol_sticky=1; pll_rst high for 4 cycles; relock -> RUN again; lol_count=1 with CNN_PLL_LOL_COUNT_EN defined, 0 without.
5. Assert restart in the same cycle as the WAIT_LOCK timeout and as a lock rise -> state is RESET next cycle, retry_cnt=0.
6. Assert rst_n low in the middle of STABLE -> all outputs take reset values asynchronously, before the next clk edge.
